// File: rtl/feature_frame_builder.sv
// Streaming front end of the keyword classifier: rescales 16-bit samples to saturated 8-bit,
// assembles ping-pong frames and presents each one to the network for a fixed settle time.
module feature_frame_builder #(
    parameter int IN_SIZE     = 64,
    parameter int SHIFT       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [15:0]       sample_in,
    input  logic                     sample_valid,
    input  logic                     frame_start,
    output logic                     sample_ready,
    output logic [IN_SIZE*8-1:0]     input_vector,
    output logic                     vector_valid,
    output logic                     nn_capture,
    output logic                     frame_err
);
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(IN_SIZE - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    logic [7:0]           buf_mem [0:1][0:IN_SIZE-1];
    logic [1:0]           full_reg, full_next;
    logic                 wr_sel_reg;
    logic [IW-1:0]        wr_idx_reg;
    logic                 rd_ptr_reg;
    state_t               state_reg, state_next;
    logic [HW-1:0]        hold_cnt_reg, hold_cnt_next;
    logic [IN_SIZE*8-1:0] input_vector_reg;
    logic                 vector_valid_reg, nn_capture_reg, frame_err_reg;

    logic signed [15:0]   shifted;
    logic [7:0]           conv;
    logic                 accept, frame_done, present_en, capture_en;
    logic [IW-1:0]        idx;

    always_comb begin
        shifted = sample_in >>> SHIFT;
        if (shifted > 16'sd127)
            conv = 8'h7F;
        else if (shifted < -16'sd128)
            conv = 8'h80;
        else
            conv = shifted[7:0];
    end

    // Ready comes only from registered flags, so a buffer freed this edge is writable next cycle.
    assign sample_ready = ~full_reg[wr_sel_reg];
    assign accept       = sample_valid & sample_ready;
    assign idx          = frame_start ? '0 : wr_idx_reg;
    assign frame_done   = accept & (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (accept)
            buf_mem[wr_sel_reg][idx] <= conv;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_reg    <= 1'b0;
            wr_idx_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= accept & frame_start & (wr_idx_reg != '0);
            if (accept) begin
                if (frame_done) begin
                    wr_idx_reg <= '0;
                    wr_sel_reg <= ~wr_sel_reg;
                end else begin
                    wr_idx_reg <= idx + 1'b1;
                end
            end
        end
    end

    // Completion and presentation always target different buffers, so both updates apply.
    always_comb begin
        full_next = full_reg;
        if (frame_done)
            full_next[wr_sel_reg] = 1'b1;
        if (present_en)
            full_next[rd_ptr_reg] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (full_reg[rd_ptr_reg]) begin
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_INIT;
                end
            end
            HOLD: begin
                if (hold_cnt_reg == '0)
                    state_next = IDLE;
                else
                    hold_cnt_next = hold_cnt_reg - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        present_en = (state_reg == IDLE) && full_reg[rd_ptr_reg];
        capture_en = (state_reg == HOLD) && (hold_cnt_reg == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_reg         <= 2'b00;
            rd_ptr_reg       <= 1'b0;
            input_vector_reg <= '0;
            vector_valid_reg <= 1'b0;
            nn_capture_reg   <= 1'b0;
        end else begin
            full_reg         <= full_next;
            vector_valid_reg <= present_en;
            nn_capture_reg   <= capture_en;
            if (present_en) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                for (int i = 0; i < IN_SIZE; i++)
                    input_vector_reg[i*8 +: 8] <= buf_mem[rd_ptr_reg][i];
            end
        end
    end

    assign input_vector = input_vector_reg;
    assign vector_valid = vector_valid_reg;
    assign nn_capture   = nn_capture_reg;
    assign frame_err    = frame_err_reg;

endmodule
